sobel_window_gen: RTL
=====================

# sobel_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge stage. It accepts a raster-order 8-bit grayscale pixel stream under a valid/ready handshake and buffers two image rows internally. For every interior pixel it emits one registered 3x3 window plus the centre coordinates, so the Sobel stage no longer issues nine ROM reads per pixel.

## Interface
- IMG_W, 64, image width in pixels (columns)
- IMG_H, 64, image height in pixels (rows)
- PIX_W, 8, pixel width in bits
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pix_in  in  PIX_W  input pixel, row-major raster order
- pix_valid  in  1  pix_in is valid
- pix_ready  out  1  block can accept; transfer when pix_valid & pix_ready
- win  out  9*PIX_W  window P0..P8 packed, P0 in bits [PIX_W-1:0], P8 in MSBs; P0 top-left, P4 centre, P8 bottom-right
- win_valid  out  1  win/win_row/win_col valid
- win_ready  in  1  downstream accepts; transfer when win_valid & win_ready
- win_row  out  7  centre row, 1..IMG_H-2
- win_col  out  7  centre column, 1..IMG_W-2
- frame_done  out  1  one-cycle pulse on the transfer of the last window of a frame

## Operation
- Input counters in_row and in_col each count 0..IMG_X-1. in_col wraps to 0 at IMG_W-1 and increments in_row. in_row wraps to 0 after pixel (IMG_H-1, IMG_W-1), which starts the next frame.
- Two line buffers, LB_A (row r-2) and LB_B (row r-1), each IMG_W deep. On every accepted pixel at column c:
  - read LB_A[c] and LB_B[c];
  - write LB_A[c] <= old LB_B[c] and LB_B[c] <= pix_in in the same cycle (read-before-write).
- The 3x3 column shift register shifts left by one column per accept. The new right column is {LB_A[c], LB_B[c], pix_in} (top to bottom).
- Emit rule: an accept with in_row>=2 and in_col>=2 loads the window into win, sets win_row=in_row-1 and win_col=in_col-1, and sets win_valid.
  - Accepts with in_col<2 never emit, so no window spans a row boundary.
  - This yields (IMG_H-2)*(IMG_W-2) = 3844 windows per 64x64 frame.
- Pixels pass through unchanged; the >>2 prescale remains in the Sobel stage.
- FSM states:
  - FILL: in_row<2, no emits. Goes to STREAM when pixel (1, IMG_W-1) is accepted.
  - STREAM: emits per the emit rule. Goes to LAST when pixel (IMG_H-1, IMG_W-1) is accepted.
  - LAST: holds until the final window transfers, pulses frame_done in that cycle, then goes to FILL.
- Line buffer contents are not cleared between frames. Stale data is never emitted because FILL suppresses output.
- Reset mid-frame: in-flight pixels and window are discarded. The next accepted pixel is treated as (0,0).

## Timing
- Reset values: win_valid=0, win=0, win_row=0, win_col=0, frame_done=0, state FILL, counters 0. pix_ready=1 (combinational from win_valid=0).
- pix_ready = ~win_valid | win_ready, combinational. There is no pix_valid to pix_ready path.
- Latency: win_valid is high in the cycle after the accepting edge of pixel (r+1, c+1) for centre (r,c).
- While win_valid & ~win_ready: win, win_row, win_col and win_valid hold stable, and no input is accepted.
- Simultaneous window transfer and a new emitting accept: the register reloads and win_valid stays 1, giving full throughput of one pixel per cycle.
- Window transfer with no emitting accept in the same cycle: win_valid falls to 0 next cycle.
- frame_done is combinational: (state==LAST) & win_valid & win_ready. It is never asserted outside LAST.
- Counter arithmetic is unsigned, widths $clog2(IMG_W) and $clog2(IMG_H). Wrap is exact at IMG_W-1 and IMG_H-1; counters never hold out-of-range values.

## Structure
- Shared package sobel_pkg holds:
  - IMG_W, IMG_H and PIX_W defaults;
  - FSM state encoding (FILL, STREAM, LAST);
  - window slot indices P0..P8 and the packing function.
- One sub-module, sobel_line_buf: a single-port IMG_W x PIX_W read-before-write buffer, instantiated twice.
- Counters, window registers, FSM and handshake stay in the top module.

## Test plan
- Ramp frame, pixel = (r*64+c) & 8'hFF, win_ready=1 → first window appears the cycle after pixel (2,2) is accepted. Expected: centre (1,1), P0..P8 = 0,1,2,64,65,66,128,129,130.
- Full ramp frame streamed continuously → exactly 3844 windows in raster order of centres (1,1)..(62,62), each matching a software model, with one frame_done on the last window.
- Hold win_ready=0 for 5 cycles while win_valid=1 → pix_ready=0 throughout, outputs stable. Release → transfer, and pixels resume with no loss or duplication.
- Row boundary: accepts of (3,0) and (3,1) → no window emitted. Accept of (3,2) → window centre (2,1).
- Assert reset after 100 pixels → all outputs at reset values immediately. A full frame streamed afterwards reproduces the 3844 reference windows exactly.
- Two back-to-back ramp frames → no window in rows 0-1 of frame 2, frame 2 windows equal frame 1 windows, and frame_done pulses twice.

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults, FSM encoding and window slot packing for the Sobel window generator
package sobel_pkg;

    localparam int SOBEL_IMG_W = 64;
    localparam int SOBEL_IMG_H = 64;
    localparam int SOBEL_PIX_W = 8;
    localparam int ROWCOL_W    = 7;
    localparam int WIN_N       = 9;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_LAST   = 2'd2
    } sobel_state_e;

    // Window slots, raster order inside the 3x3: P0 top-left, P4 centre, P8 bottom-right
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

    function automatic int win_slot_lsb(input int slot, input int pix_w);
        return slot * pix_w;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel input stream and window output stream of the Sobel window generator
interface sobel_window_gen_if #(
    parameter int PIX_W = sobel_pkg::SOBEL_PIX_W
);
    import sobel_pkg::*;

    logic [PIX_W-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [WIN_N*PIX_W-1:0] win;
    logic                   win_valid;
    logic                   win_ready;
    logic [ROWCOL_W-1:0]    win_row;
    logic [ROWCOL_W-1:0]    win_col;
    logic                   frame_done;

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win, win_valid, win_row, win_col, frame_done
    );

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win, win_valid, win_row, win_col, frame_done
    );

endinterface

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - single-port read-before-write line buffer, one image row deep
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_IMG_W,
    parameter int WIDTH = SOBEL_PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Asynchronous read returns the old word in the same cycle the new one is written
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 neighbourhood generator feeding the Sobel edge stage
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = SOBEL_IMG_W,
    parameter int IMG_H = SOBEL_IMG_H,
    parameter int PIX_W = SOBEL_PIX_W
) (
    input  logic               clk,
    input  logic               reset,
    sobel_window_gen_if.slave  bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    sobel_state_e state, state_nxt;

    logic [ROW_W-1:0]          in_row;
    logic [COL_W-1:0]          in_col;
    logic                      accept;
    logic                      emit;
    logic                      stream_en;
    logic                      frame_done;
    logic                      row_end;
    logic                      frame_end;
    logic [PIX_W-1:0]          lb_a_rd;
    logic [PIX_W-1:0]          lb_b_rd;
    logic [2:0][PIX_W-1:0]     col_old;
    logic [2:0][PIX_W-1:0]     col_mid;
    logic [WIN_N*PIX_W-1:0]    win_d;
    logic [WIN_N*PIX_W-1:0]    win_q;
    logic                      win_valid_q;
    logic [ROWCOL_W-1:0]       win_row_q;
    logic [ROWCOL_W-1:0]       win_col_q;

    assign bus.pix_ready  = ~win_valid_q | bus.win_ready;
    assign bus.win        = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done;

    assign accept    = bus.pix_valid & bus.pix_ready;
    assign row_end   = (in_col == COL_LAST);
    assign frame_end = row_end & (in_row == ROW_LAST);
    // Columns 0 and 1 never emit so a window cannot straddle two rows
    assign emit      = accept & stream_en & (in_row >= ROW_W'(2)) & (in_col >= COL_W'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_row <= '0;
            in_col <= '0;
        end else if (accept) begin
            if (row_end) begin
                in_col <= '0;
                in_row <= (in_row == ROW_LAST) ? '0 : in_row + ROW_W'(1);
            end else begin
                in_col <= in_col + COL_W'(1);
            end
        end
    end

    // LB_A holds row r-2 and LB_B row r-1; LB_B's old word ripples down into LB_A
    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb_a (
        .clk   (clk),
        .we    (accept),
        .addr  (in_col),
        .wdata (lb_b_rd),
        .rdata (lb_a_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb_b (
        .clk   (clk),
        .we    (accept),
        .addr  (in_col),
        .wdata (bus.pix_in),
        .rdata (lb_b_rd)
    );

    // Index 0 is the top of a column, index 2 the bottom (current row)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_old <= '0;
            col_mid <= '0;
        end else if (accept) begin
            col_old <= col_mid;
            col_mid <= {bus.pix_in, lb_b_rd, lb_a_rd};
        end
    end

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            win_d[win_slot_lsb(P0 + 3 * r, PIX_W) +: PIX_W] = col_old[r];
            win_d[win_slot_lsb(P1 + 3 * r, PIX_W) +: PIX_W] = col_mid[r];
        end
        win_d[win_slot_lsb(P2, PIX_W) +: PIX_W] = lb_a_rd;
        win_d[win_slot_lsb(P5, PIX_W) +: PIX_W] = lb_b_rd;
        win_d[win_slot_lsb(P8, PIX_W) +: PIX_W] = bus.pix_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q       <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
        end else if (emit) begin
            win_q       <= win_d;
            win_row_q   <= ROWCOL_W'(in_row - ROW_W'(1));
            win_col_q   <= ROWCOL_W'(in_col - COL_W'(1));
            win_valid_q <= 1'b1;
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (accept && row_end && (in_row == ROW_W'(1))) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept && frame_end) begin
                    state_nxt = ST_LAST;
                end
            end
            ST_LAST: begin
                if (win_valid_q && bus.win_ready) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        stream_en  = (state == ST_STREAM);
        frame_done = (state == ST_LAST) & win_valid_q & bus.win_ready;
    end

endmodule
